data_out_disp: RTL and testbench
================================

# data_out_disp

Processor output port driving a 4-digit multiplexed 7-segment display. It is the write-side counterpart of the keypad input port on the same port bus. Port writes shift hex nibbles into a 16-bit digit register or load the blank and decimal-point masks. A free-running prescaler scans the digits, and a status flag tells software that a write has reached the display.

## Interface
- REFRESH_DIV, 16'd50000: clk cycles each digit is driven; legal range 1..65535.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- DataIn  input  4  write data from the processor.
- PortID  input  2  register select: 0 digit shift, 1 blank mask, 2 dp mask, 3 clear/status.
- PortWrite  input  1  one-cycle write strobe.
- PortRead  input  1  one-cycle read strobe.
- DataOut  output  4  combinational readback of the register selected by PortID.
- An  output  4  digit enables, active-low, one-hot-low or all ones; bit 0 is the rightmost digit.
- Seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- Dp  output  1  decimal point, active-low.

## Operation
- State:
  - Digits[15:0]: digit 0 is [3:0].
  - Blank[3:0]: 1 = digit dark.
  - DpMask[3:0]: 1 = point lit.
  - Updated flag.
  - Prescaler[15:0].
  - Index[1:0].
- Writes (PortWrite=1):
  - PortID 0: Digits <= {Digits[11:0], DataIn}. Digit 3 is discarded; a new digit enters on the right.
  - PortID 1: Blank <= DataIn.
  - PortID 2: DpMask <= DataIn.
  - PortID 3: Digits <= 0, Blank <= 0, DpMask <= 0. DataIn is ignored.
- Updated:
  - Set by any write.
  - Cleared by PortRead with PortID==3.
  - If a set and a clear occur in the same cycle, the set wins.
- DataOut, combinational from the current registers:
  - PortID 0: Digits[3:0].
  - PortID 1: Blank.
  - PortID 2: DpMask.
  - PortID 3: {3'b000, Updated}.
  - A read in the same cycle as a write returns the pre-write value.
- PortRead has no side effect except for PortID 3.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap cycle, Index <= Index+1 mod 4 (3 -> 0).
  - With REFRESH_DIV=1, Index advances every cycle.
- Drive, registered from the current Index, Digits, Blank and DpMask:
  - Unblanked digit n: An = ~(1<<n), Seg = hexdecode(Digits[4n+3:4n]), Dp = ~DpMask[n].
  - Blanked digit n: An = 4'b1111, Seg = 7'h7F, Dp = 1.
- Hex decode (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

## Timing
- Reset values:
  - Digits=0, Blank=0, DpMask=0, Updated=0, Prescaler=0, Index=0.
  - An=4'b1111, Seg=7'h7F, Dp=1.
  - DataOut follows the registers (0 for every PortID).
- First cycle after reset deasserts: An=4'b1110, Seg=1000000, Dp=1.
- Write latency:
  - A register written at edge k is visible on DataOut after edge k.
  - It reaches An/Seg/Dp at edge k+1 when that digit is currently selected; otherwise it appears when the scan reaches the digit.
- Index change: outputs reflect the new Index one edge after the wrap edge. Each digit is driven for exactly REFRESH_DIV cycles.
- Writes never reset Prescaler or Index. Clear (PortID 3) does not stop the scan.
- Reset asserted mid-scan or mid-write:
  - All state returns to its reset values on that edge.
  - A write in the same cycle as reset is discarded.
- Back-to-back writes on consecutive cycles are all accepted. There is no busy condition.

## Test plan
- Reset, REFRESH_DIV=4, idle 16 cycles -> An cycles 1110, 1101, 1011, 0111 with 4 cycles each; Seg=1000000 throughout; Dp=1.
- Shift writes 1,2,3,4,5 on PortID 0 -> Digits=16'h2345. While An=0111, Seg=0100100 (digit '2'). Read PortID 0 -> DataOut=4'h5.
- Write Blank=4'b0101 and DpMask=4'b0010 -> digits 0 and 2 show An=1111 and Seg=7'h7F in their slots; digit 1 shows Dp=0.
- Write on PortID 1, then read PortID 3 -> DataOut=0001, then 0000 on the next read. A write and a status read in the same cycle -> that read returns the old value and Updated stays 1.
- Write PortID 3 with Digits=16'hABCD -> Digits, Blank and DpMask all 0; Index continues counting without restarting.
- Assert reset for 1 cycle while index=2 and a write is in the same cycle -> next cycle An=1110, Digits=0, the write is lost, Updated=0.

Source files
------------

// File: rtl/data_out_disp.sv
// ============================================================================
//  Module      : data_out_disp
//  Description : Port-bus output register block that scans a 4-digit
//                multiplexed 7-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_out_disp #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] DataIn,
    input  logic [1:0] PortID,
    input  logic       PortWrite,
    input  logic       PortRead,
    output logic [3:0] DataOut,
    output logic [3:0] An,
    output logic [6:0] Seg,
    output logic       Dp
);

    localparam logic [1:0]  c_id_digit  = 2'd0;
    localparam logic [1:0]  c_id_blank  = 2'd1;
    localparam logic [1:0]  c_id_dp     = 2'd2;
    localparam logic [1:0]  c_id_status = 2'd3;
    localparam logic [15:0] c_div_last  = REFRESH_DIV - 16'd1;
    localparam logic [6:0]  c_seg_off   = 7'h7F;
    localparam logic [3:0]  c_an_off    = 4'b1111;

    logic [15:0] digits_q, digits_d;
    logic [3:0]  blank_q,  blank_d;
    logic [3:0]  dpmask_q, dpmask_d;
    logic        updated_q, updated_d;
    logic [15:0] presc_q,  presc_d;
    logic [1:0]  index_q,  index_d;
    logic [3:0]  an_q,     an_d;
    logic [6:0]  seg_q,    seg_d;
    logic        dp_q,     dp_d;

    logic [3:0]  w_nibble;
    logic        w_wrap;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hexdecode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    always_comb begin
        digits_d  = digits_q;
        blank_d   = blank_q;
        dpmask_d  = dpmask_q;
        updated_d = updated_q;
        if (PortRead && (PortID == c_id_status)) begin
            updated_d = 1'b0;
        end
        // Set after clear so a simultaneous write keeps the flag raised
        if (PortWrite) begin
            updated_d = 1'b1;
            case (PortID)
                c_id_digit: digits_d = {digits_q[11:0], DataIn};
                c_id_blank: blank_d  = DataIn;
                c_id_dp:    dpmask_d = DataIn;
                default: begin
                    digits_d = 16'h0000;
                    blank_d  = 4'h0;
                    dpmask_d = 4'h0;
                end
            endcase
        end
    end

    assign w_wrap = (presc_q == c_div_last);

    always_comb begin
        presc_d = w_wrap ? 16'h0000 : presc_q + 16'd1;
        index_d = w_wrap ? index_q + 2'd1 : index_q;
    end

    always_comb begin
        case (index_q)
            2'd0:    w_nibble = digits_q[3:0];
            2'd1:    w_nibble = digits_q[7:4];
            2'd2:    w_nibble = digits_q[11:8];
            default: w_nibble = digits_q[15:12];
        endcase
    end

    always_comb begin
        an_d  = c_an_off;
        seg_d = c_seg_off;
        dp_d  = 1'b1;
        if (!blank_q[index_q]) begin
            an_d  = ~(4'b0001 << index_q);
            seg_d = hexdecode(w_nibble);
            dp_d  = ~dpmask_q[index_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q  <= 16'h0000;
            blank_q   <= 4'h0;
            dpmask_q  <= 4'h0;
            updated_q <= 1'b0;
            presc_q   <= 16'h0000;
            index_q   <= 2'd0;
            an_q      <= c_an_off;
            seg_q     <= c_seg_off;
            dp_q      <= 1'b1;
        end else begin
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            dpmask_q  <= dpmask_d;
            updated_q <= updated_d;
            presc_q   <= presc_d;
            index_q   <= index_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    // Readback reflects pre-write register contents
    always_comb begin
        case (PortID)
            c_id_digit:  DataOut = digits_q[3:0];
            c_id_blank:  DataOut = blank_q;
            c_id_dp:     DataOut = dpmask_q;
            default:     DataOut = {3'b000, updated_q};
        endcase
    end

    assign An  = an_q;
    assign Seg = seg_q;
    assign Dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_data_out_disp.sv
// ============================================================================
//  Module      : tb_data_out_disp
//  Description : Self-checking bench for data_out_disp with a spec-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_out_disp;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] DataIn;
    logic [1:0] PortID;
    logic       PortWrite;
    logic       PortRead;
    logic [3:0] DataOut;
    logic [3:0] An;
    logic [6:0] Seg;
    logic       Dp;

    int checks   = 0;
    int failures = 0;

    data_out_disp #(.REFRESH_DIV(16'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .DataIn    (DataIn),
        .PortID    (PortID),
        .PortWrite (PortWrite),
        .PortRead  (PortRead),
        .DataOut   (DataOut),
        .An        (An),
        .Seg       (Seg),
        .Dp        (Dp)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model state: digits as a 4-entry array, scan position from cycles since reset
    logic [3:0] m_dig [4];
    logic [3:0] m_blank, m_dp;
    logic       m_upd;
    int         m_cycles;
    bit         started = 0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            m_blank  = 4'h0;
            m_dp     = 4'h0;
            m_upd    = 1'b0;
            m_cycles = 0;
            e_an     = 4'b1111;
            e_seg    = 7'h7F;
            e_dp     = 1'b1;
        end else begin
            int pos;
            pos = (m_cycles / DIV) % 4;
            if (m_blank[pos]) begin
                e_an  = 4'b1111;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an      = 4'b1111;
                e_an[pos] = 1'b0;
                e_seg     = hex_tab[m_dig[pos]];
                e_dp      = !m_dp[pos];
            end
            if (PortRead && PortID == 2'd3) m_upd = 1'b0;
            if (PortWrite) begin
                m_upd = 1'b1;
                case (PortID)
                    2'd0: begin
                        for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
                        m_dig[0] = DataIn;
                    end
                    2'd1: m_blank = DataIn;
                    2'd2: m_dp    = DataIn;
                    default: begin
                        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
                        m_blank = 4'h0;
                        m_dp    = 4'h0;
                    end
                endcase
            end
            m_cycles++;
        end
    end

    function automatic logic [3:0] exp_dataout();
        case (PortID)
            2'd0:    return m_dig[0];
            2'd1:    return m_blank;
            2'd2:    return m_dp;
            default: return {3'b000, m_upd};
        endcase
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("model_an",  {12'h0, An},  {12'h0, e_an});
            chk("model_seg", {9'h0, Seg},  {9'h0, e_seg});
            chk("model_dp",  {15'h0, Dp},  {15'h0, e_dp});
            chk("model_dataout", {12'h0, DataOut}, {12'h0, exp_dataout()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] id, input logic [3:0] d);
        PortWrite = 1'b1;
        PortID    = id;
        DataIn    = d;
        cyc();
        PortWrite = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] v, input string nm);
        for (int k = 0; k < 40 && An !== v; k++) cyc();
        chk(nm, {12'h0, An}, {12'h0, v});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] an_lit [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        int nblank, ndp1;
        reset = 1'b1; DataIn = 4'h0; PortID = 2'd0; PortWrite = 1'b0; PortRead = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_an",  {12'h0, An},  16'h000F);
        chk("rst_seg", {9'h0, Seg},  16'h007F);
        chk("rst_dp",  {15'h0, Dp},  16'h0001);
        PortID = 2'd3;
        #1;
        chk("rst_status", {12'h0, DataOut}, 16'h0000);
        PortID = 2'd0;

        // Idle scan: each digit held for DIV cycles
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("idle_an",  {12'h0, An}, {12'h0, an_lit[i/4]});
            chk("idle_seg", {9'h0, Seg}, 16'h0040);
            chk("idle_dp",  {15'h0, Dp}, 16'h0001);
        end

        for (int k = 1; k <= 5; k++) wr(2'd0, 4'(k));
        PortID = 2'd0;
        #1;
        chk("shift_digit0", {12'h0, DataOut}, 16'h0005);
        wait_an(4'b0111, "wait_digit3");
        chk("digit3_seg", {9'h0, Seg}, 16'h0024);

        wr(2'd1, 4'b0101);
        wr(2'd2, 4'b0010);
        cyc();
        nblank = 0;
        ndp1   = 0;
        for (int i = 0; i < 16; i++) begin
            if (An == 4'b1111 && Seg == 7'h7F) nblank++;
            if (Dp == 1'b0 && An == 4'b1101) ndp1++;
            cyc();
        end
        chk("blank_slots", 16'(nblank), 16'd8);
        chk("dp_slots",    16'(ndp1),   16'd4);

        wr(2'd1, 4'b0000);
        PortID = 2'd3; PortRead = 1'b1;
        #1;
        chk("status_set", {12'h0, DataOut}, 16'h0001);
        cyc();
        chk("status_clr", {12'h0, DataOut}, 16'h0000);
        PortRead = 1'b0;
        PortID = 2'd0;

        // Every hex glyph passes through the display
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) wr(2'd0, 4'(4*g + k));
            for (int i = 0; i < 16; i++) cyc();
        end
        wait_an(4'b1110, "wait_digit0");
        chk("digit0_F", {9'h0, Seg}, 16'h000E);

        wr(2'd0, 4'hA); wr(2'd0, 4'hB); wr(2'd0, 4'hC); wr(2'd0, 4'hD);
        PortID = 2'd0;
        #1;
        chk("abcd_digit0", {12'h0, DataOut}, 16'h000D);
        wr(2'd3, 4'hF);
        for (int id = 0; id < 3; id++) begin
            PortID = 2'(id);
            #1;
            chk("clear_reg", {12'h0, DataOut}, 16'h0000);
        end
        for (int i = 0; i < 8; i++) cyc();

        PortID = 2'd3; PortRead = 1'b1;
        cyc();
        PortWrite = 1'b1;
        #1;
        chk("wr_rd_old", {12'h0, DataOut}, 16'h0000);
        cyc();
        PortWrite = 1'b0; PortRead = 1'b0;
        #1;
        chk("wr_rd_setwins", {12'h0, DataOut}, 16'h0001);

        wr(2'd0, 4'h9);
        wait_an(4'b1011, "wait_digit2");
        reset = 1'b1; PortWrite = 1'b1; PortID = 2'd0; DataIn = 4'h7;
        cyc();
        reset = 1'b0; PortWrite = 1'b0;
        chk("midrst_an",  {12'h0, An}, 16'h000F);
        chk("midrst_seg", {9'h0, Seg}, 16'h007F);
        #1;
        chk("midrst_digit0", {12'h0, DataOut}, 16'h0000);
        PortID = 2'd3;
        #1;
        chk("midrst_status", {12'h0, DataOut}, 16'h0000);
        cyc();
        chk("postrst_an",  {12'h0, An}, 16'h000E);
        chk("postrst_seg", {9'h0, Seg}, 16'h0040);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
